// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: fetch port, load/store port, shared memory
// bus and grant flags. The master modport is the arbiter's view; the slave
// modport is the view of everything around it (cpu stages plus memory slave).
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // instruction fetch port
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic              i_waitrequest;
  logic [DATA_W-1:0] i_readdata;

  // load/store port
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [DATA_W-1:0] d_writedata;
  logic [BE_W-1:0]   d_byteenable;
  logic              d_waitrequest;
  logic [DATA_W-1:0] d_readdata;

  // shared memory bus
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  // ownership flags
  logic              grant_i;
  logic              grant_d;

  modport master (
    input  i_address, i_read,
    input  d_address, d_read, d_write, d_writedata, d_byteenable,
    input  waitrequest, readdata,
    output i_waitrequest, i_readdata,
    output d_waitrequest, d_readdata,
    output address, read, write, writedata, byteenable,
    output grant_i, grant_d
  );

  modport slave (
    output i_address, i_read,
    output d_address, d_read, d_write, d_writedata, d_byteenable,
    output waitrequest, readdata,
    input  i_waitrequest, i_readdata,
    input  d_waitrequest, d_readdata,
    input  address, read, write, writedata, byteenable,
    input  grant_i, grant_d
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the CPU's single Avalon-style memory port.
// Fetch (i) and load/store (d) compete; a registered owner state selects
// which requester drives the bus. Ties go to DATA_FIRST's choice unless
// the fetch port has lost STARVE_LIMIT arbitrations in a row.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_FIRST   = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_bus_arbiter_if.master bus
);
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  starve_cnt, starve_nx;
  logic [DATA_W-1:0] i_hold, d_hold;
  logic [ADDR_W-1:0] addr_mux;
  logic              i_req, d_req, tie_to_i;

  assign i_req    = bus.i_read;
  assign d_req    = bus.d_read | bus.d_write;
  assign tie_to_i = (starve_cnt == CNT_MAX) || (DATA_FIRST == 0);
  assign bus.address = addr_mux;

  // Owner state and fetch starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
    end
  end

  // Last completed read data per port, shown while that port is not owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      if (state == OWN_I && bus.i_read && !bus.waitrequest)
        i_hold <= bus.readdata;
      if (state == OWN_D && bus.d_read && !bus.d_write && !bus.waitrequest)
        d_hold <= bus.readdata;
    end
  end

  // Arbitration, completion detection and the state-selected bus mux.
  always_comb begin
    state_nx          = state;
    starve_nx         = starve_cnt;
    addr_mux          = '0;
    bus.read          = 1'b0;
    bus.write         = 1'b0;
    bus.writedata     = '0;
    bus.byteenable    = '0;
    bus.i_waitrequest = 1'b1;
    bus.d_waitrequest = 1'b1;
    bus.i_readdata    = i_hold;
    bus.d_readdata    = d_hold;
    bus.grant_i       = 1'b0;
    bus.grant_d       = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (tie_to_i) begin
            state_nx  = OWN_I;
            starve_nx = '0;
          end else begin
            // d only wins while the counter is below its limit, so +1 saturates
            state_nx  = OWN_D;
            starve_nx = starve_cnt + CNT_W'(1);
          end
        end else if (i_req) begin
          state_nx  = OWN_I;
          starve_nx = '0;
        end else if (d_req) begin
          state_nx = OWN_D;
        end
      end

      OWN_I: begin
        addr_mux          = bus.i_address;
        bus.read          = bus.i_read;
        bus.byteenable    = '1;
        bus.i_waitrequest = bus.waitrequest;
        bus.i_readdata    = bus.readdata;
        bus.grant_i       = 1'b1;
        if (!i_req || !bus.waitrequest)
          state_nx = IDLE;
      end

      OWN_D: begin
        addr_mux          = bus.d_address;
        // a simultaneous read and write is treated as a write
        bus.write         = bus.d_write;
        bus.read          = bus.d_read & ~bus.d_write;
        bus.writedata     = bus.d_writedata;
        bus.byteenable    = bus.d_byteenable;
        bus.d_waitrequest = bus.waitrequest;
        bus.d_readdata    = bus.readdata;
        bus.grant_d       = 1'b1;
        if (!d_req || !bus.waitrequest)
          state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scenario tasks drive the two
// requester ports, queue the bus accesses they expect in arbitration order,
// and a bus monitor pops and compares each completed access.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port_d;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } op_t;

  op_t sbq[$];
  op_t i_ops[$];
  op_t d_ops[$];

  logic        slave_wait = 1'b0;
  bit          rand_wait = 1'b0;
  logic        rd_override_en = 1'b0;
  logic [31:0] rd_override = '0;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .DATA_FIRST(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif.master)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // memory slave: data is a fixed function of the bus address
  assign bif.readdata    = rd_override_en ? rd_override : mem_fn(bif.address);
  assign bif.waitrequest = slave_wait;

  function automatic op_t mk_i(input logic [31:0] a);
    op_t o;
    o.port_d = 1'b0; o.rd = 1'b1; o.wr = 1'b0;
    o.addr = a; o.wdata = '0; o.be = 4'hF; o.rdata = mem_fn(a);
    return o;
  endfunction

  function automatic op_t mk_d(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] w, input logic [3:0] be);
    op_t o;
    o.port_d = 1'b1; o.rd = rd; o.wr = wr;
    o.addr = a; o.wdata = w; o.be = be; o.rdata = wr ? 32'h0 : mem_fn(a);
    return o;
  endfunction

  // Bus monitor: invariants every cycle, scoreboard pop on each completion.
  always @(negedge clk) begin : monitor
    op_t         e;
    logic [31:0] ra;
    logic        wa;
    bit          bad;
    if (reset) begin
      checks++;
      if ((bif.grant_i && bif.grant_d) || (bif.read && bif.write)) begin
        errors++;
        $display("FAIL invariant: grant_i=%b grant_d=%b read=%b write=%b, required no pair both high",
                 bif.grant_i, bif.grant_d, bif.read, bif.write);
      end
      if ((bif.read || bif.write) && !bif.waitrequest) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: access addr=%h rd=%b wr=%b, required no access",
                   bif.address, bif.read, bif.write);
        end else begin
          e   = sbq.pop_front();
          ra  = e.port_d ? bif.d_readdata : bif.i_readdata;
          wa  = e.port_d ? bif.d_waitrequest : bif.i_waitrequest;
          bad = (bif.grant_d !== e.port_d) || (bif.grant_i !== !e.port_d) ||
                (bif.write !== e.wr) || (bif.read !== !e.wr) ||
                (bif.address !== e.addr) || (bif.byteenable !== e.be) ||
                (e.wr && bif.writedata !== e.wdata) || (!e.wr && ra !== e.rdata) ||
                (wa !== 1'b0);
          if (bad) begin
            errors++;
            $display("FAIL sb_access: got gd=%b wr=%b rd=%b a=%h wd=%h be=%h rdata=%h wait=%b; required gd=%b wr=%b a=%h wd=%h be=%h rdata=%h wait=0",
                     bif.grant_d, bif.write, bif.read, bif.address, bif.writedata,
                     bif.byteenable, ra, wa, e.port_d, e.wr, e.addr, e.wdata, e.be, e.rdata);
          end
        end
      end
    end
  end

  // Agents: each port holds its request until its waitrequest drops.
  // Entered and left at posedge+1.
  task automatic run_traffic(input int budget, input string name);
    int  cycles = 0;
    bit  i_act = 0, d_act = 0, i_done, d_done;
    op_t o;
    while ((i_ops.size() != 0 || d_ops.size() != 0 || i_act || d_act) && cycles < budget) begin
      if (!i_act && i_ops.size() != 0) begin
        o = i_ops.pop_front();
        bif.i_address = o.addr; bif.i_read = 1'b1; i_act = 1;
      end
      if (!d_act && d_ops.size() != 0) begin
        o = d_ops.pop_front();
        bif.d_address = o.addr; bif.d_read = o.rd; bif.d_write = o.wr;
        bif.d_writedata = o.wdata; bif.d_byteenable = o.be; d_act = 1;
      end
      if (rand_wait) slave_wait = 1'($urandom_range(0, 1));
      @(negedge clk);
      i_done = i_act && !bif.i_waitrequest;
      d_done = d_act && !bif.d_waitrequest;
      @(posedge clk); #1;
      cycles++;
      if (i_done) begin i_act = 0; bif.i_read = 1'b0; end
      if (d_done) begin d_act = 0; bif.d_read = 1'b0; bif.d_write = 1'b0; end
    end
    slave_wait = 1'b0;
    checks++;
    if (cycles >= budget) begin
      errors++;
      $display("FAIL %s_timeout: %0d cycles used, required under %0d", name, cycles, budget);
      bif.i_read = 1'b0; bif.d_read = 1'b0; bif.d_write = 1'b0;
      i_ops.delete(); d_ops.delete();
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d accesses outstanding, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    bif.i_address = 32'h1000; bif.i_read = 1'b1;
    bif.d_address = 32'h2000; bif.d_read = 1'b0; bif.d_write = 1'b1;
    bif.d_writedata = 32'hFFFF_FFFF; bif.d_byteenable = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bif.read !== 1'b0 || bif.write !== 1'b0 || bif.i_waitrequest !== 1'b1 ||
        bif.d_waitrequest !== 1'b1 || bif.grant_i !== 1'b0 || bif.grant_d !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rd=%b wr=%b iw=%b dw=%b gi=%b gd=%b, required 0 0 1 1 0 0",
               bif.read, bif.write, bif.i_waitrequest, bif.d_waitrequest, bif.grant_i, bif.grant_d);
    end
    checks++;
    if (bif.address !== 32'h0 || bif.writedata !== 32'h0 || bif.byteenable !== 4'h0 ||
        dut.starve_cnt !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wd=%h be=%h starve=%0d, required all 0",
               bif.address, bif.writedata, bif.byteenable, dut.starve_cnt);
    end
    bif.i_read = 1'b0; bif.d_write = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    op_t e;
    rd_override_en = 1'b1; rd_override = 32'h2413_0005; slave_wait = 1'b0;
    e = mk_i(32'hBFC0_0000); e.rdata = 32'h2413_0005;
    sbq.push_back(e);
    bif.i_address = 32'hBFC0_0000; bif.i_read = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.read !== 1'b0 || bif.i_waitrequest !== 1'b1 || bif.grant_i !== 1'b0) begin
      errors++;
      $display("FAIL fetch_arb_cycle: rd=%b iw=%b gi=%b, required 0 1 0",
               bif.read, bif.i_waitrequest, bif.grant_i);
    end
    @(negedge clk);
    checks++;
    if (bif.read !== 1'b1 || bif.address !== 32'hBFC0_0000 || bif.i_waitrequest !== 1'b0 ||
        bif.i_readdata !== 32'h2413_0005) begin
      errors++;
      $display("FAIL fetch_xfer_cycle: rd=%b addr=%h iw=%b idata=%h, required 1 bfc00000 0 24130005",
               bif.read, bif.address, bif.i_waitrequest, bif.i_readdata);
    end
    @(posedge clk); #1;
    bif.i_read = 1'b0; rd_override_en = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.read !== 1'b0 || bif.grant_i !== 1'b0 || bif.i_readdata !== 32'h2413_0005) begin
      errors++;
      $display("FAIL fetch_hold: rd=%b gi=%b idata=%h, required 0 0 24130005",
               bif.read, bif.grant_i, bif.i_readdata);
    end
    @(posedge clk); #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL fetch_drain: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_tie();
    op_t d0, i0;
    d0 = mk_d(1'b0, 1'b1, 32'h0000_012C, 32'h4, 4'hF);
    i0 = mk_i(32'hBFC0_0004);
    d_ops.push_back(d0); i_ops.push_back(i0);
    sbq.push_back(d0); sbq.push_back(i0);
    run_traffic(40, "tie");
    checks++;
    if (dut.starve_cnt !== '0) begin
      errors++;
      $display("FAIL tie_starve_clear: starve_cnt=%0d, required 0", dut.starve_cnt);
    end
  endtask

  task automatic test_starvation();
    op_t d[6];
    op_t i0;
    for (int k = 0; k < 6; k++) begin
      d[k] = mk_d(1'b0, 1'b1, 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'hF);
      d_ops.push_back(d[k]);
    end
    i0 = mk_i(32'hBFC0_0010);
    i_ops.push_back(i0);
    // fetch loses four arbitrations, wins the fifth
    for (int k = 0; k < 4; k++) sbq.push_back(d[k]);
    sbq.push_back(i0);
    sbq.push_back(d[4]); sbq.push_back(d[5]);
    run_traffic(100, "starve");
    checks++;
    if (dut.starve_cnt !== '0) begin
      errors++;
      $display("FAIL starve_clear: starve_cnt=%0d, required 0", dut.starve_cnt);
    end
  endtask

  task automatic test_stall();
    op_t d0, i0;
    d0 = mk_d(1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'h3);
    i0 = mk_i(32'h1000);
    sbq.push_back(d0); sbq.push_back(i0);
    slave_wait = 1'b1;
    bif.d_address = d0.addr; bif.d_writedata = d0.wdata; bif.d_byteenable = d0.be;
    bif.d_read = 1'b0; bif.d_write = 1'b1;
    bif.i_address = i0.addr; bif.i_read = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bif.d_waitrequest !== 1'b1 || bif.i_waitrequest !== 1'b1 || bif.write !== 1'b1 ||
          bif.address !== 32'h200 || bif.writedata !== 32'hDEAD_BEEF ||
          bif.byteenable !== 4'h3 || bif.grant_d !== 1'b1) begin
        errors++;
        $display("FAIL stall_cycle%0d: dw=%b iw=%b wr=%b a=%h wd=%h be=%h gd=%b, required 1 1 1 200 deadbeef 3 1",
                 k, bif.d_waitrequest, bif.i_waitrequest, bif.write, bif.address,
                 bif.writedata, bif.byteenable, bif.grant_d);
      end
    end
    @(posedge clk); #1;
    slave_wait = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.d_waitrequest !== 1'b0 || bif.i_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL stall_complete: dw=%b iw=%b, required 0 1", bif.d_waitrequest, bif.i_waitrequest);
    end
    @(posedge clk); #1;
    bif.d_write = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    bif.i_read = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_rw_conflict();
    op_t d0;
    d0 = mk_d(1'b1, 1'b1, 32'h40, 32'h1122_3344, 4'hC);
    d_ops.push_back(d0); sbq.push_back(d0);
    run_traffic(20, "rw_conflict");
  endtask

  task automatic test_drop();
    slave_wait = 1'b1;
    bif.d_address = 32'h300; bif.d_byteenable = 4'hF;
    bif.d_read = 1'b1; bif.d_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bif.grant_d !== 1'b1 || bif.read !== 1'b1) begin
      errors++;
      $display("FAIL drop_own: gd=%b rd=%b, required 1 1", bif.grant_d, bif.read);
    end
    @(posedge clk); #1;
    bif.d_read = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.read !== 1'b0 || bif.write !== 1'b0 || bif.grant_d !== 1'b1) begin
      errors++;
      $display("FAIL drop_strobe: rd=%b wr=%b gd=%b, required 0 0 1", bif.read, bif.write, bif.grant_d);
    end
    @(negedge clk);
    checks++;
    if (bif.grant_d !== 1'b0 || bif.d_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL drop_idle: gd=%b dw=%b, required 0 1", bif.grant_d, bif.d_waitrequest);
    end
    @(posedge clk); #1;
    slave_wait = 1'b0;
  endtask

  task automatic test_back_to_back();
    op_t dq[$];
    op_t iq[$];
    op_t o;
    int  sel;
    logic [31:0] a;
    for (int k = 0; k < 8; k++) begin
      sel = int'($urandom_range(0, 2));
      a = $urandom; a[1:0] = 2'b00;
      o = mk_d(sel != 1, sel != 0, a, $urandom, 4'($urandom_range(1, 15)));
      dq.push_back(o); d_ops.push_back(o);
    end
    for (int k = 0; k < 3; k++) begin
      a = $urandom; a[1:0] = 2'b00;
      o = mk_i(a);
      iq.push_back(o); i_ops.push_back(o);
    end
    for (int k = 0; k < 4; k++) sbq.push_back(dq[k]);
    sbq.push_back(iq[0]);
    for (int k = 4; k < 8; k++) sbq.push_back(dq[k]);
    sbq.push_back(iq[1]); sbq.push_back(iq[2]);
    rand_wait = 1;
    run_traffic(600, "b2b");
    rand_wait = 0;
  endtask

  task automatic test_reset_mid();
    op_t d0;
    d0 = mk_d(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 4'hF);
    slave_wait = 1'b1;
    bif.d_address = d0.addr; bif.d_writedata = d0.wdata; bif.d_byteenable = d0.be;
    bif.d_read = 1'b0; bif.d_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bif.write !== 1'b1 || bif.grant_d !== 1'b1) begin
      errors++;
      $display("FAIL rmid_own: wr=%b gd=%b, required 1 1", bif.write, bif.grant_d);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (bif.write !== 1'b0 || bif.read !== 1'b0 || bif.d_waitrequest !== 1'b1 ||
        bif.grant_d !== 1'b0 || bif.address !== 32'h0) begin
      errors++;
      $display("FAIL rmid_async: wr=%b rd=%b dw=%b gd=%b addr=%h, required 0 0 1 0 0",
               bif.write, bif.read, bif.d_waitrequest, bif.grant_d, bif.address);
    end
    bif.d_write = 1'b0; slave_wait = 1'b0;
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bif.grant_d !== 1'b0 || bif.grant_i !== 1'b0 || dut.starve_cnt !== '0) begin
      errors++;
      $display("FAIL rmid_idle: gd=%b gi=%b starve=%0d, required 0 0 0",
               bif.grant_d, bif.grant_i, dut.starve_cnt);
    end
    d_ops.push_back(d0); sbq.push_back(d0);
    run_traffic(20, "rmid_reissue");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.i_address = '0; bif.i_read = 1'b0;
    bif.d_address = '0; bif.d_read = 1'b0; bif.d_write = 1'b0;
    bif.d_writedata = '0; bif.d_byteenable = '0;
    test_reset();
    test_fetch();
    test_tie();
    test_starvation();
    test_stall();
    test_rw_conflict();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
